// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVERFLOW_EN.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
`ifdef SERIAL_ADD_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             c_reg;
  logic [CntW-1:0]  cnt;

  logic fa_sum;
  logic fa_carry;

  always_comb begin
    fa_sum   = a_reg[0] ^ b_reg[0] ^ c_reg;
    fa_carry = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      a_reg    <= '0;
      b_reg    <= '0;
      acc_reg  <= '0;
      c_reg    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryOut <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= inA;
            b_reg <= inB;
            c_reg <= carryIn;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          c_reg   <= fa_carry;
          acc_reg <= {fa_sum, acc_reg[WIDTH-1:1]};
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          cnt     <= cnt + CntW'(1);
          if (cnt == LastCnt) begin
            // acc_reg holds bits 0..WIDTH-2 in its upper WIDTH-1 positions at this point
            sum      <= {fa_sum, acc_reg[WIDTH-1:1]};
            carryOut <= fa_carry;
`ifdef SERIAL_ADD_OVERFLOW_EN
            overflow <= c_reg ^ fa_carry;
`endif
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
